// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants for the BCD display driver
package seg_pkg;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [15:0][6:0] SEG_LUT = {
        {6{7'h79}},
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational 4-bit code to active-high abcdefg segment pattern
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[code];
endmodule

// File: rtl/bcd_seg_display_driver.sv
// bcd_seg_display_driver: synchronizes asynchronous BCD counts, captures stable
// values and time-multiplexes them onto a common-anode seven-segment display.
module bcd_seg_display_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD       = 2
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    digit_err
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] s1, s2, s3, captured;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [3:0]              digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_above, err_bits;
    logic [6:0]              seg_code;
    logic                    wrap, dead, blank;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            assign digit_arr[g]  = captured[4*g +: 4];
            assign zero_above[g] = captured[4*NUM_DIGITS-1:4*g] == '0;
            assign err_bits[g]   = digit_arr[g] > 4'd9;
        end
    endgenerate

    bcd_to_seg u_dec (
        .code (digit_arr[idx]),
        .seg  (seg_code)
    );

    assign digit_err = |err_bits;
    assign wrap      = presc == PW'(SCAN_DIV - 1);
    assign dead      = presc < PW'(DEAD);
    assign blank     = blank_lz && idx != '0 && zero_above[idx];

    // s2 == s3 means the sample survived two consecutive edges, so a value
    // caught mid-ripple is never captured
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            captured <= '0;
            presc    <= '0;
            idx      <= '0;
            seg_n    <= BLANK;
            an_n     <= '1;
        end else begin
            s1       <= bcd_in;
            s2       <= s1;
            s3       <= s2;
            captured <= (load && s2 == s3) ? s2 : captured;
            presc    <= wrap ? '0 : presc + 1'b1;
            idx      <= wrap ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
            an_n     <= dead ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg_n    <= (dead || blank) ? BLANK : ~seg_code;
        end
    end
endmodule
